// File: rtl/sram_share_arb.sv
// sram_share_arb
// Two-requester arbiter and fill sequencer for the shared 64x8 project SRAM.
// Port A (CPU core) and port B (management/debug loader) share the array; at
// most one access is granted per cycle, round-robin under contention. A sweep
// engine writes FILL to every word after reset (CLEAR_ON_RESET) or on clear_i.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   clear_i                 start a fill sweep (sampled only while idle)
//   busy_o                  sweep in progress, no grants issued
//   a_/b_req, _we, _addr, _wdata   client requests
//   a_/b_gnt                combinational grant
//   a_/b_rvalid, _rdata     read response, one cycle after the grant
//   sram_addr, sram_in, sram_gwe, sram_out   SRAM pins (synchronous read)
//   dbg_state               current sequencer state (0 = IDLE, 1 = SWEEP)
//
// Handshake: a client raises *_req with stable *_we/*_addr/*_wdata and holds
// all of them until the cycle in which *_gnt is high; that cycle is the
// transfer. *_gnt never rises without *_req. A granted read returns data with
// *_rvalid high for exactly one cycle, on the cycle after the grant.
module sram_share_arb #(
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0] FILL           = 8'h00
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       clear_i,
    output logic       busy_o,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [5:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_rvalid,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [5:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_rvalid,
    output logic [7:0] b_rdata,
    output logic [5:0] sram_addr,
    output logic [7:0] sram_in,
    output logic       sram_gwe,
    input  logic [7:0] sram_out,
    output logic       dbg_state
);

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [5:0] cnt;
    logic       last_b;   // 1 = B was granted most recently, so A wins a tie
    logic [5:0] addr_q;   // last driven SRAM address/data, held on idle cycles
    logic [7:0] in_q;
    logic [5:0] addr_d;
    logic [7:0] in_d;

    always_comb begin
        state_nxt = state;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        sram_gwe  = 1'b0;
        addr_d    = addr_q;
        in_d      = in_q;
        if (wb_rst_i) begin
            addr_d = 6'd0;
            in_d   = 8'd0;
        end else begin
            case (state)
                SWEEP: begin
                    addr_d   = cnt;
                    in_d     = FILL;
                    sram_gwe = 1'b1;
                    if (cnt == 6'd63) state_nxt = IDLE;
                end
                default: begin
                    if (a_req && (!b_req || last_b)) a_gnt = 1'b1;
                    else if (b_req)                  b_gnt = 1'b1;
                    if (a_gnt) begin
                        addr_d   = a_addr;
                        in_d     = a_wdata;
                        sram_gwe = a_we;
                    end else if (b_gnt) begin
                        addr_d   = b_addr;
                        in_d     = b_wdata;
                        sram_gwe = b_we;
                    end
                    // The cycle's grant still completes; the sweep starts after it.
                    if (clear_i) state_nxt = SWEEP;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= CLEAR_ON_RESET ? SWEEP : IDLE;
            cnt      <= 6'd0;
            last_b   <= 1'b1;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            addr_q   <= 6'd0;
            in_q     <= 8'd0;
        end else begin
            state <= state_nxt;
            // Wraps 63 -> 0 as the sweep ends, so the next sweep starts at 0.
            if (state == SWEEP) cnt <= cnt + 6'd1;
            if (a_gnt)      last_b <= 1'b0;
            else if (b_gnt) last_b <= 1'b1;
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            addr_q   <= addr_d;
            in_q     <= in_d;
        end
    end

    assign sram_addr = addr_d;
    assign sram_in   = in_d;
    assign a_rdata   = sram_out;
    assign b_rdata   = sram_out;
    assign busy_o    = (state == SWEEP) && !wb_rst_i;
    assign dbg_state = state;

endmodule

// File: doc/sram_share_arb.md
# sram_share_arb

Two-requester arbiter and clear sequencer for the shared 64×8 project SRAM (6-bit address, 8-bit data, global write-enable, synchronous read). It sits between the project multiplexer's SRAM pins and two clients: port A (CPU core) and port B (management/debug loader). It grants at most one access per cycle, round-robin under contention, and owns a sweep engine that fills the whole array with a constant after reset or on command.

## Interface
- `CLEAR_ON_RESET`, 1: when 1, a fill sweep starts automatically on reset release.
- `FILL`, 8'h00: data value written by the sweep.
- `wb_clk_i` input 1: the single clock; all state changes on its rising edge.
- `wb_rst_i` input 1: reset, synchronous and active-high.
- `clear_i` input 1: start a fill sweep; sampled only while idle.
- `busy_o` output 1: sweep in progress; no grants issued.
- `a_req`, `b_req` input 1: access request; hold it, together with `*_we`, `*_addr` and `*_wdata`, until `*_gnt`.
- `a_we`, `b_we` input 1: 1 = write, 0 = read.
- `a_addr`, `b_addr` input 6: word address.
- `a_wdata`, `b_wdata` input 8: write data.
- `a_gnt`, `b_gnt` output 1: request accepted this cycle (combinational).
- `a_rvalid`, `b_rvalid` output 1: registered; read data valid this cycle.
- `a_rdata`, `b_rdata` output 8: equal to `sram_out`; meaningful only when the matching `*_rvalid` is high.
- `sram_addr` output 6, `sram_in` output 8, `sram_gwe` output 1: SRAM drive.
- `sram_out` input 8: SRAM read data, valid one cycle after its address is presented.

## Operation
- **State:** IDLE or SWEEP, plus a 6-bit sweep counter `cnt`, a round-robin flag `last_b`, and the `a_rvalid`/`b_rvalid` registers.
- **Reset (`wb_rst_i` high):**
  - Loads `cnt`=0, `last_b`=1 (A wins the first tie), and both `rvalid`=0.
  - Loads state SWEEP if `CLEAR_ON_RESET`=1, otherwise IDLE.
  - While `wb_rst_i` is high, `a_gnt`, `b_gnt` and `sram_gwe` are forced 0, and `sram_addr`/`sram_in` are 0.
  - A reset in mid-sweep abandons the sweep and restarts per `CLEAR_ON_RESET`.
- **SWEEP:**
  - Each cycle drives `sram_addr`=`cnt`, `sram_in`=`FILL`, `sram_gwe`=1, then increments `cnt`.
  - After the cycle with `cnt`=63, `cnt` wraps to 0 and the state returns to IDLE.
  - `busy_o`=1 throughout. Both grants are 0 and requests stay pending. `clear_i` is ignored.
- **IDLE, arbitration:**
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant B if `last_b`=0, otherwise grant A.
  - `last_b` updates to the granted port on every grant, whether or not the grant was contended.
- **Granted access:**
  - Drives `sram_addr`/`sram_in` from the winner.
  - `sram_gwe` = winner's `we`.
  - The winner's `rvalid` is set next cycle if `we`=0.
- **No grant in a cycle:** `sram_gwe`=0. `sram_addr` and `sram_in` hold their last driven values (registered mux select), so there is no spurious toggling.
- **`clear_i` in IDLE:**
  - `clear_i` high enters SWEEP next cycle.
  - If `clear_i` and requests arrive in the same cycle, the requests are still arbitrated and granted that cycle, and the sweep begins on the following cycle.
- **Back-to-back accesses:** one grant per cycle, full throughput.
  - Read-after-write to the same address on the next cycle returns the new data.
  - A write in the cycle directly after a read does not disturb the previous read's `rdata`, since `sram_out` reflects the earlier address.

## Timing
- **Grant:** same cycle as the request, when IDLE.
- **Read latency:** `rvalid` is high exactly one cycle after the granting cycle, for exactly one cycle per read.
- **Write:** completes at the rising edge that ends the granting cycle.
- **Sweep:** exactly 64 cycles with `busy_o`=1. The first grant is possible in cycle 64 after the sweep starts.
  - With `CLEAR_ON_RESET`=1, this means cycles 0–63 after the first edge with `wb_rst_i` low.
- **Contention:** worst-case wait for a continuously requesting port is 1 cycle when both ports request continuously; the ports then alternate A, B, A, B.

## Test plan
- **Reset sweep:** `CLEAR_ON_RESET`=1, `FILL`=8'hA5, release reset -> `busy_o` high for exactly 64 cycles, `sram_gwe`=1 with addresses 0..63, then read address 17 via A -> `a_rvalid` next cycle with `a_rdata`=8'hA5.
- **Contention fairness:** both ports hold reads continuously for 6 cycles -> grants A, B, A, B, A, B; each `rvalid` is one cycle after its grant; the other port's `rvalid` stays 0.
- **Write/read pairing:** B writes 8'h3C to address 5 in cycle n, A reads address 5 in cycle n+1 -> `a_rvalid` in cycle n+2 with `a_rdata`=8'h3C.
- **Clear command with pending request:** `clear_i` and `a_req` read both high in the same IDLE cycle -> A granted that cycle; 64-cycle sweep follows; a `b_req` raised during the sweep is granted in the first post-sweep cycle.
- **Reset mid-sweep:** assert `wb_rst_i` at sweep cycle 30 with `CLEAR_ON_RESET`=0 -> during reset, grants and `sram_gwe` are 0; after reset the state is IDLE, `busy_o`=0, and a request is granted immediately.
